// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//
// Multi-cycle sequencer that owns the port of a shared 16-bit ALU
// (add/sub/and/not). It accepts one operation per start/done handshake.
//
// Single ALU operations finish in one EXEC cycle. Unsigned 16x16 multiply
// (low 16 bits of the product) and unsigned 16/16 restoring divide each run
// 16 EXEC iterations. Every iteration uses exactly one ALU add or subtract.
//
// Optional feature macro: ALU_SEQ_EARLY_EXIT_EN
//   When defined, MUL leaves EXEC after the iteration in which the shifted
//   multiplier becomes zero, so a multiplier of 0 takes one iteration.
//   DIV timing and single-op timing are the same in both builds.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous, active-high reset
//   start      in   1   request; sampled only in IDLE
//   op         in   3   000 ADD, 001 SUB, 010 AND, 011 NOT(A), 100 MUL,
//                       101 DIV, 11x executed as ADD
//   opa        in  16   operand A / multiplicand / dividend
//   opb        in  16   operand B / multiplier / divisor
//   busy       out  1   high while in EXEC
//   done       out  1   one-cycle completion pulse (DONE state)
//   result     out 16   ALU result / product low / quotient
//   remainder  out 16   DIV remainder, 0 for every other op
//   zero       out  1   registered together with result, 1 when result == 0
//   div_zero   out  1   DIV requested with opb == 0
//   alu_a      out 16   to ALU A input (0 outside EXEC)
//   alu_b      out 16   to ALU B input (0 outside EXEC)
//   alu_op     out  2   to ALU op (00 add, 01 sub, 10 and, 11 not)
//   alu_out    in  16   combinational ALU result for the current cycle
// ---------------------------------------------------------------------------
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [15:0] remainder,
    output logic        zero,
    output logic        div_zero,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_out
);

    // state | meaning
    // ------+-------------------------------------------------------------
    // IDLE  | waiting for start; ALU port driven to zero / add
    // EXEC  | one ALU operation per cycle (single op, MUL or DIV iteration)
    // DONE  | one-cycle completion pulse, then back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_DIV  = 3'b101;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] a_q, a_d;          // single-op operand A
    logic [15:0] b_q, b_d;          // single-op B / multiplicand (shifting) / divisor
    logic [15:0] acc_q, acc_d;      // MUL accumulator / DIV partial remainder
    logic [15:0] shf_q, shf_d;      // MUL multiplier / DIV quotient
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic [15:0] remainder_q, remainder_d;
    logic        zero_q, zero_d;
    logic        div_zero_q, div_zero_d;

    logic        is_mul;
    logic        is_div;
    logic        last_iter;
    logic        mul_last;
    logic [15:0] mul_acc_next;
    logic [15:0] mul_mplier_next;
    logic [16:0] div_shift;
    logic        div_ge;
    logic [15:0] div_r_next;
    logic [15:0] div_q_next;

    // -----------------------------------------------------------------------
    // Datapath helpers
    // -----------------------------------------------------------------------
    assign is_mul    = (op_q == OP_MUL);
    assign is_div    = (op_q == OP_DIV);
    assign last_iter = (cnt_q == 4'd15);

    // MUL: add the multiplicand only when the current multiplier LSB is set.
    assign mul_acc_next    = shf_q[0] ? alu_out : acc_q;
    assign mul_mplier_next = shf_q >> 1;

`ifdef ALU_SEQ_EARLY_EXIT_EN
    // Once every remaining multiplier bit is zero the accumulator is final.
    assign mul_last = last_iter || (mul_mplier_next == 16'd0);
`else
    assign mul_last = last_iter;
`endif

    // DIV: the partial remainder is conceptually 17 bits, but after each
    // restoring step it is always below the divisor, so the stored MSB is
    // always 0 and only the shifted value needs the 17th bit.
    assign div_shift  = {1'b0, acc_q, shf_q[15]};
    assign div_ge     = (div_shift >= {1'b0, b_q});
    // When div_ge holds, div_shift - D < D < 2^16, so the 16-bit ALU
    // difference of the low halves is the exact new remainder.
    assign div_r_next = div_ge ? alu_out : div_shift[15:0];
    assign div_q_next = {shf_q[14:0], div_ge};

    // -----------------------------------------------------------------------
    // Next-state and ALU port
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        shf_d       = shf_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        zero_d      = zero_q;
        div_zero_d  = div_zero_q;
        alu_a       = 16'd0;
        alu_b       = 16'd0;
        alu_op      = ALU_ADD;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d        = op;
                    cnt_d       = 4'd0;
                    acc_d       = 16'd0;
                    result_d    = 16'd0;
                    remainder_d = 16'd0;
                    zero_d      = 1'b0;
                    div_zero_d  = 1'b0;
                    if (op == OP_DIV) begin
                        b_d   = opb;
                        shf_d = opa;
                        if (opb == 16'd0) begin
                            result_d    = 16'hFFFF;
                            remainder_d = opa;
                            div_zero_d  = 1'b1;
                            state_d     = ST_DONE;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end else if (op == OP_MUL) begin
                        b_d     = opa;
                        shf_d   = opb;
                        state_d = ST_EXEC;
                    end else begin
                        a_d     = opa;
                        b_d     = opb;
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                if (is_mul) begin
                    alu_a  = acc_q;
                    alu_b  = b_q;
                    alu_op = ALU_ADD;
                    acc_d  = mul_acc_next;
                    b_d    = b_q << 1;
                    shf_d  = mul_mplier_next;
                    cnt_d  = cnt_q + 4'd1;
                    if (mul_last) begin
                        result_d = mul_acc_next;
                        zero_d   = (mul_acc_next == 16'd0);
                        cnt_d    = 4'd0;
                        state_d  = ST_DONE;
                    end
                end else if (is_div) begin
                    alu_a  = div_shift[15:0];
                    alu_b  = b_q;
                    alu_op = ALU_SUB;
                    acc_d  = div_r_next;
                    shf_d  = div_q_next;
                    cnt_d  = cnt_q + 4'd1;
                    if (last_iter) begin
                        result_d    = div_q_next;
                        remainder_d = div_r_next;
                        zero_d      = (div_q_next == 16'd0);
                        cnt_d       = 4'd0;
                        state_d     = ST_DONE;
                    end
                end else begin
                    alu_a    = a_q;
                    alu_b    = b_q;
                    // Reserved 11x codes run as ADD rather than AND/NOT.
                    alu_op   = op_q[2] ? ALU_ADD : op_q[1:0];
                    result_d = alu_out;
                    zero_d   = (alu_out == 16'd0);
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            a_q         <= 16'd0;
            b_q         <= 16'd0;
            acc_q       <= 16'd0;
            shf_q       <= 16'd0;
            cnt_q       <= 4'd0;
            result_q    <= 16'd0;
            remainder_q <= 16'd0;
            zero_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            shf_q       <= shf_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            zero_q      <= zero_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = (state_q == ST_EXEC);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign remainder = remainder_q;
    assign zero      = zero_q;
    assign div_zero  = div_zero_q;

endmodule
